mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the MIPS core.
- Executes MULT, MULTU, DIV and DIVU.
- Drives the write side of the HI/LO register file: w_hi, hi_data, w_lo, lo_data.
- The pipeline stalls on busy; an exception or flush aborts an in-flight operation through cancel.

Parameters:
- WIDTH, 32: operand width; hi_data and lo_data are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock    in   1      rising-edge clock
- resetn   in   1      asynchronous active-low reset
- start    in   1      request; sampled only in IDLE
- op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a    in   WIDTH  rs operand (multiplicand/dividend)
- src_b    in   WIDTH  rt operand (multiplier/divisor)
- cancel   in   1      abort the in-flight operation, no write
- busy     out  1      operation in progress; pipeline stall request
- w_hi     out  1      HI write enable, one-cycle pulse
- hi_data  out  WIDTH  product high word / remainder
- w_lo     out  1      LO write enable, one-cycle pulse
- lo_data  out  WIDTH  product low word / quotient

Behaviour:
- Reset (resetn=0, asynchronous) forces state IDLE, busy=0, w_hi=0, w_lo=0, hi_data=0, lo_data=0, counter=0.
- States:
  - IDLE: start=1 latches op, src_a, src_b and moves to CALC with counter=0.
  - CALC: one radix-2 iteration per cycle; counter increments; after WIDTH iterations go to DONE.
  - DONE: w_hi=w_lo=1 for exactly one cycle with final hi_data/lo_data; next state IDLE.
- All outputs are registered. busy = (state != IDLE).
- Latency: start accepted at edge T, so CALC occupies cycles T+1..T+WIDTH and DONE is cycle T+WIDTH+1 (T+33 for WIDTH=32). The HI/LO file captures at the end of DONE.
- w_hi and w_lo are always asserted together; no partial writes.
- Multiply: shift-add over 2*WIDTH-bit accumulator. Signed ops use operand magnitudes, then negate the 64-bit product if sign_a^sign_b. hi = product[63:32], lo = product[31:0].
- Divide: restoring division on magnitudes.
  - Signed: quotient negated if sign_a^sign_b; remainder takes sign of src_a.
  - Unsigned: raw operands.
- Boundary conditions:
  - Divide by zero (either signedness): lo=all-ones, hi=src_a unmodified, same latency.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
  - start while busy: ignored; operands are not re-latched.
  - start in the DONE cycle: ignored; accepted only in IDLE the following cycle.
  - cancel in CALC or DONE: next state IDLE, w_hi/w_lo stay 0 (cancel wins over DONE's write), hi_data/lo_data keep their last values.
  - cancel in IDLE: no effect, including when start is asserted in the same cycle (start is then dropped).
  - Asynchronous reset mid-operation: immediate return to IDLE, no write.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU compute a full product with a single registered multiplier and go IDLE→DONE directly; write occurs at T+1, busy is high for one cycle. DIV/DIVU unchanged.
- Undefined: all four ops use the iterative path with WIDTH+1 cycle latency.

Decomposition:
- Package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encoding: IDLE, CALC, DONE
  - WIDTH default constant
- One sub-module mdu_sign_fix (combinational): operand magnitude extraction plus result negation/sign correction, instantiated for pre- and post-processing.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 → at T+33 w_hi=w_lo=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high T+1..T+33.
- MULTU a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007 at T+33.
- DIVU 100/7 with cancel at T+10 → busy low from T+11, no w_hi/w_lo pulse ever; a new start at T+11 is accepted and produces a correct result.
- start re-pulsed with new operands at T+5 and in the DONE cycle → ignored; the original result is written once. With MDU_FAST_MUL_EN, MULT 3×4 → lo=12, hi=0 at T+1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and default width for the multiply/divide unit.
// Optional single-cycle multiply path is enabled by defining MDU_FAST_MUL_EN.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Two's-complement conditional negation: yields operand magnitudes on the way in
// and applies quotient/remainder/product sign correction on the way out.
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU with one registered multiplier.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             w_hi,
    output logic [WIDTH-1:0] hi_data,
    output logic             w_lo,
    output logic [WIDTH-1:0] lo_data
);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_dz;
    logic             r_busy;
    logic             r_wr;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_raw_a;
    logic [WIDTH-1:0] r_hi_data;
    logic [WIDTH-1:0] r_lo_data;

    logic             w_in_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_in_signed = ~op[0];
    assign w_sign_a    = w_in_signed & src_a[WIDTH-1];
    assign w_sign_b    = w_in_signed & src_b[WIDTH-1];

    mdu_sign_fix #(.N(WIDTH)) u_pre_a (.i_val(src_a), .i_neg(w_sign_a), .o_val(w_a_mag));
    mdu_sign_fix #(.N(WIDTH)) u_pre_b (.i_val(src_b), .i_neg(w_sign_b), .o_val(w_b_mag));

    // One iteration step. Multiply shifts {hi,lo} right after a conditional add;
    // divide shifts left and keeps the trial difference when it does not borrow.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    always_comb begin
        w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
        w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_opb};
        // NOTE: every output gets a value on every path, so no latch is inferred.
        if (r_is_div) begin
            w_hi_nxt = w_diff[WIDTH+1] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_lo_nxt = {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH+1]};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] w_prod_raw;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_prod_neg;

`ifdef MDU_FAST_MUL_EN
    logic w_fast;

    // In IDLE the product path serves the single-cycle multiplier, otherwise the last iteration.
    assign w_fast     = (r_state == IDLE);
    assign w_prod_raw = w_fast ? ({{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag})
                               : {w_hi_nxt, w_lo_nxt};
    assign w_prod_neg = w_fast ? (w_sign_a ^ w_sign_b) : (r_sign_a ^ r_sign_b);
`else
    assign w_prod_raw = {w_hi_nxt, w_lo_nxt};
    assign w_prod_neg = r_sign_a ^ r_sign_b;
`endif

    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    mdu_sign_fix #(.N(2*WIDTH)) u_post_p (.i_val(w_prod_raw), .i_neg(w_prod_neg), .o_val(w_prod));
    mdu_sign_fix #(.N(WIDTH)) u_post_q (.i_val(w_lo_nxt), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_quo));
    mdu_sign_fix #(.N(WIDTH)) u_post_r (.i_val(w_hi_nxt), .i_neg(r_sign_a), .o_val(w_rem));

    // Divide by zero bypasses the datapath: quotient all ones, remainder is the raw dividend.
    assign w_res_hi = !r_is_div ? w_prod[2*WIDTH-1:WIDTH] : (r_dz ? r_raw_a : w_rem);
    assign w_res_lo = !r_is_div ? w_prod[WIDTH-1:0]       : (r_dz ? '1      : w_quo);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_dz      <= 1'b0;
            r_busy    <= 1'b0;
            r_wr      <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opb     <= '0;
            r_raw_a   <= '0;
            r_hi_data <= '0;
            r_lo_data <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !cancel) begin
                        r_is_div <= op[1];
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_dz     <= (src_b == '0);
                        r_raw_a  <= src_a;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_a_mag;
                        r_opb    <= w_b_mag;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                        if (!op[1]) begin
                            r_state   <= DONE;
                            r_wr      <= 1'b1;
                            r_hi_data <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo_data <= w_prod[WIDTH-1:0];
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc_hi <= w_hi_nxt;
                        r_acc_lo <= w_lo_nxt;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state   <= DONE;
                            r_wr      <= 1'b1;
                            r_hi_data <= w_res_hi;
                            r_lo_data <= w_res_lo;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A cancel raised during DONE still suppresses the write pulse.
    assign busy    = r_busy;
    assign w_hi    = r_wr & ~cancel;
    assign w_lo    = r_wr & ~cancel;
    assign hi_data = r_hi_data;
    assign lo_data = r_lo_data;

endmodule
